modexp_io_buffer: RTL and testbench

- Device-side responder for the word-serial operand/result protocol the host bench drives into the 4096-bit modular exponentiation core.
- Assembles the 64-bit operand words (m, e, n, r, t) into word-addressed storage and gates compute start.
- Captures result words written by the core and streams them back to the host on request.
- Sits between the host-facing buffers (m_buf…t_buf, res_out) and the exponentiation datapath.

---
 rtl/modexp_io_buffer_pkg.sv | 16 +
 rtl/modexp_word_ram.sv | 29 ++
 rtl/modexp_io_buffer.sv | 113 +++++++++++
 tb/tb_modexp_io_buffer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modexp_io_buffer_pkg.sv
// modexp_io_buffer_pkg: shared sizes and FSM encoding for the modexp operand/result buffer
// Operand and result words always travel least-significant word first (word index 0 = LS word).
package modexp_io_buffer_pkg;
    localparam int DATA_WIDTH = 64;
    localparam int NUM_WORDS  = 64;
    localparam int ADDR_W     = 6;
    localparam int CNT_W      = ADDR_W + 1;
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_LOADED = 3'd2,
        S_BUSY   = 3'd3,
        S_RESULT = 3'd4,
        S_DRAIN  = 3'd5
    } io_state_t;
endpackage

// File: rtl/modexp_word_ram.sv
// modexp_word_ram: word-addressed store with one write port and one registered, enabled read port
module modexp_word_ram
    import modexp_io_buffer_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int NW = NUM_WORDS,
    parameter int AW = ADDR_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [NW];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Disabled reads hold the last word so the drain output can park on it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) o_rdata <= '0;
        else if (i_re) o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/modexp_io_buffer.sv
// modexp_io_buffer: loads operand words for the modexp core, gates its start and streams results back
module modexp_io_buffer
    import modexp_io_buffer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  startInput,
    input  logic                  startCompute,
    input  logic                  getResult,
    input  logic [DATA_WIDTH-1:0] m_buf,
    input  logic [DATA_WIDTH-1:0] e_buf,
    input  logic [DATA_WIDTH-1:0] n_buf,
    input  logic [DATA_WIDTH-1:0] r_buf,
    input  logic [DATA_WIDTH-1:0] t_buf,
    output logic [DATA_WIDTH-1:0] res_out,
    output logic                  res_valid,
    output logic                  load_done,
    output logic [2:0]            io_state,
    output logic                  core_go,
    input  logic [ADDR_W-1:0]     core_rd_addr,
    output logic [DATA_WIDTH-1:0] core_m,
    output logic [DATA_WIDTH-1:0] core_e,
    output logic [DATA_WIDTH-1:0] core_n,
    output logic [DATA_WIDTH-1:0] core_r,
    output logic [DATA_WIDTH-1:0] core_t,
    input  logic                  core_res_we,
    input  logic [ADDR_W-1:0]     core_res_addr,
    input  logic [DATA_WIDTH-1:0] core_res_data,
    input  logic                  core_done
);
    io_state_t        r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic             r_core_go, r_load_done, r_res_valid;
    logic             w_last, w_go_nx, w_load_done_nx, w_op_we, w_res_we, w_res_re;
    logic [DATA_WIDTH-1:0] w_op_in  [5];
    logic [DATA_WIDTH-1:0] w_op_out [5];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_core_go   <= 1'b0;
            r_load_done <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_core_go   <= w_go_nx;
            r_load_done <= w_load_done_nx;
            r_res_valid <= w_res_re;
        end
    end

    // Counter only runs while streaming; every other state holds it cleared for the next entry
    always_comb begin
        w_last     = r_cnt == CNT_W'(NUM_WORDS - 1);
        w_cnt_nx   = (r_state == S_LOAD || r_state == S_DRAIN) ? r_cnt + 1'b1 : '0;
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:   w_state_nx = startInput ? S_LOAD : S_IDLE;
            S_LOAD:   w_state_nx = w_last ? S_LOADED : S_LOAD;
            S_LOADED: w_state_nx = startInput ? S_LOAD : startCompute ? S_BUSY : S_LOADED;
            S_BUSY:   w_state_nx = core_done ? S_RESULT : S_BUSY;
            S_RESULT: w_state_nx = startInput ? S_LOAD : getResult ? S_DRAIN : S_RESULT;
            S_DRAIN:  w_state_nx = w_last ? S_IDLE : S_DRAIN;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        w_go_nx        = r_state == S_LOADED && startCompute && !startInput;
        w_load_done_nx = r_state == S_LOAD && w_last;
        w_op_we        = r_state == S_LOAD;
        w_res_we       = r_state == S_BUSY && core_res_we;
        w_res_re       = r_state == S_DRAIN;
    end

    assign w_op_in = '{m_buf, e_buf, n_buf, r_buf, t_buf};

    for (genvar g = 0; g < 5; g++) begin : g_op
        modexp_word_ram u_op (
            .clk     (clk),
            .reset   (reset),
            .i_we    (w_op_we),
            .i_waddr (r_cnt[ADDR_W-1:0]),
            .i_wdata (w_op_in[g]),
            .i_re    (1'b1),
            .i_raddr (core_rd_addr),
            .o_rdata (w_op_out[g])
        );
    end

    modexp_word_ram u_res (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_res_we),
        .i_waddr (core_res_addr),
        .i_wdata (core_res_data),
        .i_re    (w_res_re),
        .i_raddr (r_cnt[ADDR_W-1:0]),
        .o_rdata (res_out)
    );

    assign core_m    = w_op_out[0];
    assign core_e    = w_op_out[1];
    assign core_n    = w_op_out[2];
    assign core_r    = w_op_out[3];
    assign core_t    = w_op_out[4];
    assign core_go   = r_core_go;
    assign load_done = r_load_done;
    assign res_valid = r_res_valid;
    assign io_state  = r_state;
endmodule

// File: tb/tb_modexp_io_buffer.sv
// tb_modexp_io_buffer: directed scenario tests for the modexp operand/result buffer
module tb_modexp_io_buffer;
    logic        clk = 1'b0;
    logic        reset, startInput, startCompute, getResult;
    logic [63:0] m_buf, e_buf, n_buf, r_buf, t_buf;
    logic [63:0] res_out;
    logic        res_valid, load_done, core_go;
    logic [2:0]  io_state;
    logic [5:0]  core_rd_addr, core_res_addr;
    logic [63:0] core_m, core_e, core_n, core_r, core_t, core_res_data;
    logic        core_res_we, core_done;

    logic [63:0] m_w [64];
    logic [63:0] e_w [64];
    logic [63:0] n_w [64];
    logic [63:0] r_w [64];
    logic [63:0] t_w [64];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    modexp_io_buffer dut (
        .clk(clk), .reset(reset), .startInput(startInput), .startCompute(startCompute),
        .getResult(getResult), .m_buf(m_buf), .e_buf(e_buf), .n_buf(n_buf), .r_buf(r_buf),
        .t_buf(t_buf), .res_out(res_out), .res_valid(res_valid), .load_done(load_done),
        .io_state(io_state), .core_go(core_go), .core_rd_addr(core_rd_addr), .core_m(core_m),
        .core_e(core_e), .core_n(core_n), .core_r(core_r), .core_t(core_t),
        .core_res_we(core_res_we), .core_res_addr(core_res_addr), .core_res_data(core_res_data),
        .core_done(core_done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic [63:0] m0, input logic [63:0] e0, input logic [63:0] n0);
        for (int i = 0; i < 64; i++) begin
            m_w[i] = (i == 0) ? m0 : 64'd0;
            e_w[i] = (i == 0) ? e0 : 64'd0;
            n_w[i] = (i == 0) ? n0 : 64'd0;
            r_w[i] = 64'h0123_4567_89AB_CDEF ^ (64'(i) * 64'h0101_0101);
            t_w[i] = ~(64'(i) << 8);
        end
    endtask

    // Streams all 64 words; optionally pokes host pulses mid-load, or stops early at abort_at
    task automatic load_ops(input bit do_start, input int abort_at, input bit poke);
        if (do_start) begin
            startInput = 1'b1;
            tick;
            startInput = 1'b0;
        end
        for (int i = 0; i < 64; i++) begin
            if (i == abort_at) return;
            m_buf = m_w[i]; e_buf = e_w[i]; n_buf = n_w[i]; r_buf = r_w[i]; t_buf = t_w[i];
            if (poke && i == 10) begin startCompute = 1'b1; getResult = 1'b1; end
            tick;
            startCompute = 1'b0;
            getResult = 1'b0;
            if (i < 63) begin
                checks++;
                if (io_state !== 3'd1 || load_done !== 1'b0 || core_go !== 1'b0 || res_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL load_word%0d: state=%0d load_done=%b core_go=%b res_valid=%b, want 1/0/0/0",
                             i, io_state, load_done, core_go, res_valid);
                end
            end
        end
        checks++;
        if (io_state !== 3'd2 || load_done !== 1'b1) begin
            errors++;
            $display("FAIL load_end: state=%0d load_done=%b, want 2/1", io_state, load_done);
        end
        tick;
        checks++;
        if (load_done !== 1'b0 || io_state !== 3'd2) begin
            errors++;
            $display("FAIL load_done_pulse: load_done=%b state=%0d, want 0/2", load_done, io_state);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        checks++;
        if (io_state !== 3'd0 || res_valid !== 1'b0 || load_done !== 1'b0 || core_go !== 1'b0 ||
            res_out !== 64'd0 || core_m !== 64'd0 || core_t !== 64'd0) begin
            errors++;
            $display("FAIL reset_state: state=%0d rv=%b ld=%b go=%b res=%h m=%h t=%h, want all 0",
                     io_state, res_valid, load_done, core_go, res_out, core_m, core_t);
        end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_ignored_idle;
        getResult = 1'b1;
        startCompute = 1'b1;
        core_done = 1'b1;
        tick;
        getResult = 1'b0;
        startCompute = 1'b0;
        core_done = 1'b0;
        tick;
        checks++;
        if (io_state !== 3'd0 || res_valid !== 1'b0 || core_go !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore: state=%0d rv=%b go=%b, want 0/0/0", io_state, res_valid, core_go);
        end
    endtask

    task automatic test_core_read;
        core_rd_addr = 6'd0;
        tick;
        checks++;
        if (core_m !== m_w[0] || core_e !== e_w[0] || core_n !== n_w[0] || core_r !== r_w[0] || core_t !== t_w[0]) begin
            errors++;
            $display("FAIL core_read0: m=%h e=%h n=%h r=%h t=%h, want %h %h %h %h %h",
                     core_m, core_e, core_n, core_r, core_t, m_w[0], e_w[0], n_w[0], r_w[0], t_w[0]);
        end
        core_rd_addr = 6'd63;
        tick;
        checks++;
        if (core_m !== 64'd0 || core_r !== r_w[63] || core_t !== t_w[63]) begin
            errors++;
            $display("FAIL core_read63: m=%h r=%h t=%h, want 0 %h %h", core_m, core_r, core_t, r_w[63], t_w[63]);
        end
    endtask

    task automatic test_compute(input logic [63:0] w0);
        startCompute = 1'b1;
        tick;
        startCompute = 1'b0;
        checks++;
        if (core_go !== 1'b1 || io_state !== 3'd3) begin
            errors++;
            $display("FAIL compute_go: go=%b state=%0d, want 1/3", core_go, io_state);
        end
        core_rd_addr = 6'd0;
        tick;
        checks++;
        if (core_go !== 1'b0 || core_n !== n_w[0]) begin
            errors++;
            $display("FAIL compute_go_pulse: go=%b core_n=%h, want 0/%h", core_go, core_n, n_w[0]);
        end
        for (int a = 63; a >= 0; a--) begin
            core_res_we = 1'b1;
            core_res_addr = 6'(a);
            core_res_data = (a == 0) ? w0 : 64'd0;
            core_done = (a == 0);
            tick;
        end
        core_res_we = 1'b0;
        core_done = 1'b0;
        checks++;
        if (io_state !== 3'd4 || core_go !== 1'b0) begin
            errors++;
            $display("FAIL compute_done: state=%0d go=%b, want 4/0", io_state, core_go);
        end
    endtask

    task automatic test_drain(input logic [63:0] w0);
        getResult = 1'b1;
        tick;
        getResult = 1'b0;
        checks++;
        if (io_state !== 3'd5 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_entry: state=%0d rv=%b, want 5/0", io_state, res_valid);
        end
        for (int k = 0; k < 64; k++) begin
            tick;
            checks++;
            if (res_valid !== 1'b1 || res_out !== ((k == 0) ? w0 : 64'd0)) begin
                errors++;
                $display("FAIL drain_word%0d: rv=%b res=%h, want 1/%h", k, res_valid, res_out, (k == 0) ? w0 : 64'd0);
            end
        end
        checks++;
        if (io_state !== 3'd0) begin
            errors++;
            $display("FAIL drain_exit_state: state=%0d, want 0", io_state);
        end
        tick;
        checks++;
        if (res_valid !== 1'b0 || res_out !== 64'd0 || io_state !== 3'd0) begin
            errors++;
            $display("FAIL drain_tail: rv=%b res=%h state=%0d, want 0/0/0", res_valid, res_out, io_state);
        end
    endtask

    task automatic test_back_to_back;
        load_ops(1'b1, 64, 1'b0);
        startInput = 1'b1;
        startCompute = 1'b1;
        tick;
        startInput = 1'b0;
        startCompute = 1'b0;
        checks++;
        if (io_state !== 3'd1 || core_go !== 1'b0) begin
            errors++;
            $display("FAIL loaded_restart: state=%0d go=%b, want 1/0", io_state, core_go);
        end
        load_ops(1'b0, 64, 1'b0);
        test_compute(64'd50);
        startInput = 1'b1;
        getResult = 1'b1;
        tick;
        startInput = 1'b0;
        getResult = 1'b0;
        checks++;
        if (io_state !== 3'd1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL result_restart: state=%0d rv=%b, want 1/0", io_state, res_valid);
        end
        load_ops(1'b0, 64, 1'b0);
    endtask

    task automatic test_reset_mid;
        core_rd_addr = 6'd63;
        load_ops(1'b1, 30, 1'b0);
        checks++;
        if (io_state !== 3'd1 || core_r !== r_w[63]) begin
            errors++;
            $display("FAIL pre_reset_load: state=%0d r=%h, want 1/%h", io_state, core_r, r_w[63]);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (io_state !== 3'd0 || core_r !== 64'd0 || load_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_load: state=%0d r=%h ld=%b, want 0/0/0", io_state, core_r, load_done);
        end
        #2;
        reset = 1'b0;
        tick;
        core_done = 1'b1;
        tick;
        core_done = 1'b0;
        checks++;
        if (io_state !== 3'd0) begin
            errors++;
            $display("FAIL stray_core_done: state=%0d, want 0", io_state);
        end
        load_ops(1'b1, 64, 1'b0);
        test_compute(64'd50);
        getResult = 1'b1;
        tick;
        getResult = 1'b0;
        tick;
        checks++;
        if (res_valid !== 1'b1 || res_out !== 64'd50) begin
            errors++;
            $display("FAIL pre_reset_drain: rv=%b res=%h, want 1/32", res_valid, res_out);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (io_state !== 3'd0 || res_valid !== 1'b0 || res_out !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid_drain: state=%0d rv=%b res=%h, want 0/0/0", io_state, res_valid, res_out);
        end
        #2;
        reset = 1'b0;
        tick;
    endtask

    initial begin
        reset = 1'b1;
        startInput = 1'b0; startCompute = 1'b0; getResult = 1'b0;
        m_buf = '0; e_buf = '0; n_buf = '0; r_buf = '0; t_buf = '0;
        core_rd_addr = '0; core_res_we = 1'b0; core_res_addr = '0; core_res_data = '0; core_done = 1'b0;
        test_reset;
        test_ignored_idle;
        set_ops(64'd8, 64'd13, 64'd77);
        load_ops(1'b1, 64, 1'b1);
        test_core_read;
        test_compute(64'd50);
        test_drain(64'd50);
        test_back_to_back;
        test_reset_mid;
        set_ops(64'd8, 64'd37, 64'd77);
        load_ops(1'b1, 64, 1'b0);
        test_core_read;
        test_compute(64'd57);
        test_drain(64'd57);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
